// File: rtl/add_sub_pkg.sv
// Shared definitions for the chunked adder/subtractor.
//   state_e   : control FSM states (IDLE / RUN / DONE)
//   OP_ADD/SUB: encoding of the Sub input
//   idx_width : width of the chunk index counter (never below 1 bit)
package add_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int idx_width(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple adder, the single arithmetic stage shared
// by every RUN cycle of chunked_add_sub.
//   a_i, b_i  : CHUNK-bit operand slices
//   c_i       : carry in
//   sum_o     : CHUNK-bit sum
//   cout_o    : carry out of the top bit
//   cmsb_o    : carry into the top bit (used for signed overflow)
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             c_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             cout_o,
    output logic             cmsb_o
);
    logic [CHUNK:0] c;

    assign c[0] = c_i;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        one_bit_adder u_fa (
            .a_i (a_i[i]),
            .b_i (b_i[i]),
            .c_i (c[i]),
            .s_o (sum_o[i]),
            .c_o (c[i+1])
        );
    end

    assign cout_o = c[CHUNK];
    assign cmsb_o = c[CHUNK-1];
endmodule

// File: rtl/one_bit_adder.sv
// Full adder cell used to build the ripple chain.
//   a_i, b_i, c_i : operand bits and carry in
//   s_o, c_o      : sum bit and carry out
module one_bit_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

// File: rtl/chunked_add_sub.sv
// Multi-cycle WIDTH-bit adder/subtractor processing CHUNK bits per clock.
// Ports:
//   Clk, Reset     : clock, synchronous active-high reset
//   Start, Enable  : request (taken only in IDLE with Enable=1); Enable=0 stalls RUN
//   Sub, A, B, Cin : operation and operands, sampled with an accepted Start
//   Ready, Done    : IDLE indicator; one-cycle result-valid pulse
//   Sum            : result register
//   Cout, Overflow : carry out of MSB (Sub: 1 = no borrow); signed overflow
//   Zero           : Sum == 0, updated with the final chunk
module chunked_add_sub
    import add_sub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Enable,
    output logic             Ready,
    output logic             Done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Overflow,
    output logic             Zero
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = idx_width(NCHUNK);
    localparam logic [IDXW-1:0] LAST = IDXW'(NCHUNK - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;

    logic [CHUNK-1:0] a_chunk, b_chunk, ch_sum;
    logic             ch_cout, ch_cmsb;
    int               base;

    // Slice of the current chunk; idx_q never exceeds LAST so the select
    // always stays inside the operand.
    always_comb begin
        base    = int'(idx_q) * CHUNK;
        a_chunk = a_q[base +: CHUNK];
        b_chunk = b_q[base +: CHUNK];
    end

    chunk_adder #(.CHUNK(CHUNK)) u_chunk (
        .a_i    (a_chunk),
        .b_i    (b_chunk),
        .c_i    (carry_q),
        .sum_o  (ch_sum),
        .cout_o (ch_cout),
        .cmsb_o (ch_cmsb)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;

        case (state_q)
            ST_IDLE: begin
                if (Start && Enable) begin
                    // Subtraction as A + ~B + ~Cin: invert B, and the borrow-in
                    // becomes an inverted carry-in.
                    a_d     = A;
                    b_d     = (Sub == OP_ADD) ? B : ~B;
                    carry_d = Cin ^ (Sub == OP_SUB);
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (Enable) begin
                    sum_d[base +: CHUNK] = ch_sum;
                    carry_d              = ch_cout;
                    if (idx_q == LAST) begin
                        cout_d  = ch_cout;
                        ovf_d   = ch_cmsb ^ ch_cout;
                        zero_d  = (sum_d == '0);
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign Ready    = (state_q == ST_IDLE);
    assign Done     = (state_q == ST_DONE);
    assign Sum      = sum_q;
    assign Cout     = cout_q;
    assign Overflow = ovf_q;
    assign Zero     = zero_q;
endmodule
